// File: rtl/hdmi_rx_timing_detect.sv
// hdmi_rx_timing_detect
//   Receive-side timing detector for the ADV7611 output bus, running on the
//   line-locked pixel clock. It measures HS/VS/DE timing and locks after the
//   format has repeated for STABLE_FRAMES frames. While locked, it tags every
//   active pixel with x/y coordinates and sof/eol strobes.
// Ports
//   clk, reset                      pixel clock, synchronous active-high reset
//   vid_hs, vid_vs, vid_de, vid_d   raw receiver bus
//   pix_d, pix_x, pix_y, pix_valid  tagged pixel stream, 2 clk after the ports
//   sof, eol                        first pixel of frame / last DE pixel of line
//   h_total, h_active               published line timing in clocks
//   v_total, v_active               published frame timing in lines
//   locked, fmt_change              lock status and 1-cycle format-change pulse
module hdmi_rx_timing_detect #(
    parameter int unsigned H_CNT_W          = 12,
    parameter int unsigned V_CNT_W          = 11,
    parameter int unsigned STABLE_FRAMES    = 4,
    parameter bit          SYNC_ACTIVE_HIGH = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vid_hs,
    input  logic               vid_vs,
    input  logic               vid_de,
    input  logic [23:0]        vid_d,
    output logic [23:0]        pix_d,
    output logic [H_CNT_W-1:0] pix_x,
    output logic [V_CNT_W-1:0] pix_y,
    output logic               pix_valid,
    output logic               sof,
    output logic               eol,
    output logic [H_CNT_W-1:0] h_total,
    output logic [H_CNT_W-1:0] h_active,
    output logic [V_CNT_W-1:0] v_total,
    output logic [V_CNT_W-1:0] v_active,
    output logic               locked,
    output logic               fmt_change
);

    localparam int unsigned PIX_W = 24;
    localparam int unsigned SC_W  = $clog2(STABLE_FRAMES + 1);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    // Input stage and one-cycle history for edge detection
    logic             hs_r, vs_r, de_r;
    logic             hs_q, vs_q, de_q;
    logic [PIX_W-1:0] d_r;

    logic hs_rise, vs_rise, de_rise, de_fall;

    // Measurement counters and latched per-line values
    logic [H_CNT_W-1:0] hcnt, hact_cnt, h_meas, h_act_meas;
    logic [V_CNT_W-1:0] vcnt, vact;
    logic               hcnt_sat, vcnt_sat, meas_sat, meas_match;

    // Stored frame measurement used for stability comparison
    logic [H_CNT_W-1:0] st_htot, st_hact;
    logic [V_CNT_W-1:0] st_vtot, st_vact;
    logic               st_vld;

    // FSM
    state_t          state, state_nxt;
    logic [SC_W-1:0] stable_cnt, stable_nxt, stable_inc;
    logic            store_en, publish_en, clr_meas, fmt_chg_nxt, lock_nxt;

    // Pixel tagging
    logic [H_CNT_W-1:0] x_cnt, col;
    logic [V_CNT_W-1:0] y_cnt, row;
    logic               row_pend, new_frame;

    // Register and polarity-normalise the receiver bus
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_r <= 1'b0;
            vs_r <= 1'b0;
            de_r <= 1'b0;
            hs_q <= 1'b0;
            vs_q <= 1'b0;
            de_q <= 1'b0;
            d_r  <= '0;
        end else begin
            hs_r <= SYNC_ACTIVE_HIGH ? vid_hs : ~vid_hs;
            vs_r <= SYNC_ACTIVE_HIGH ? vid_vs : ~vid_vs;
            de_r <= vid_de;
            hs_q <= hs_r;
            vs_q <= vs_r;
            de_q <= de_r;
            d_r  <= vid_d;
        end
    end

    assign hs_rise = hs_r & ~hs_q;
    assign vs_rise = vs_r & ~vs_q;
    assign de_rise = de_r & ~de_q;
    assign de_fall = ~de_r & de_q;

    assign hcnt_sat = &hcnt;
    assign vcnt_sat = &vcnt;
    assign meas_sat = (&h_meas) | (&h_act_meas) | (&vcnt) | (&vact);
    assign meas_match = st_vld & ~meas_sat &
                        (h_meas == st_htot) & (h_act_meas == st_hact) &
                        (vcnt == st_vtot) & (vact == st_vact);

    // Saturating timing counters; an HS coincident with VS opens the new frame
    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt       <= '0;
            hact_cnt   <= '0;
            h_meas     <= '0;
            h_act_meas <= '0;
            vcnt       <= '0;
            vact       <= '0;
        end else begin
            if (hs_rise)
                hcnt <= H_CNT_W'(1);
            else if (!hcnt_sat)
                hcnt <= hcnt + H_CNT_W'(1);

            if (de_rise)
                hact_cnt <= H_CNT_W'(1);
            else if (de_r && !(&hact_cnt))
                hact_cnt <= hact_cnt + H_CNT_W'(1);

            if (clr_meas) begin
                h_meas     <= '0;
                h_act_meas <= '0;
            end else begin
                if (hs_rise) h_meas     <= hcnt;
                if (de_fall) h_act_meas <= hact_cnt;
            end

            if (vs_rise)
                vcnt <= hs_rise ? V_CNT_W'(1) : '0;
            else if (hs_rise && !vcnt_sat)
                vcnt <= vcnt + V_CNT_W'(1);

            if (vs_rise)
                vact <= de_rise ? V_CNT_W'(1) : '0;
            else if (de_rise && !(&vact))
                vact <= vact + V_CNT_W'(1);
        end
    end

    // Lock FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_SEARCH;
            stable_cnt <= '0;
            locked     <= 1'b0;
            fmt_change <= 1'b0;
        end else begin
            state      <= state_nxt;
            stable_cnt <= stable_nxt;
            locked     <= lock_nxt;
            fmt_change <= fmt_chg_nxt;
        end
    end

    assign stable_inc = stable_cnt + SC_W'(1);

    // Lock FSM: next state; losing HS or VS overrides any frame decision
    always_comb begin
        state_nxt   = state;
        stable_nxt  = stable_cnt;
        store_en    = 1'b0;
        publish_en  = 1'b0;
        clr_meas    = 1'b0;
        fmt_chg_nxt = 1'b0;
        if (hcnt_sat || vcnt_sat) begin
            state_nxt  = ST_SEARCH;
            stable_nxt = '0;
        end else if (vs_rise) begin
            unique case (state)
                ST_SEARCH: begin
                    clr_meas   = 1'b1;
                    stable_nxt = '0;
                    state_nxt  = ST_MEASURE;
                end
                ST_MEASURE: begin
                    store_en = 1'b1;
                    if (!meas_match) begin
                        stable_nxt = '0;
                    end else begin
                        stable_nxt = stable_inc;
                        if (stable_inc == SC_W'(STABLE_FRAMES - 1)) begin
                            state_nxt  = ST_LOCKED;
                            publish_en = 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    store_en = 1'b1;
                    if (meas_match) begin
                        publish_en = 1'b1;
                    end else begin
                        fmt_chg_nxt = 1'b1;
                        stable_nxt  = '0;
                        state_nxt   = ST_MEASURE;
                    end
                end
                default: state_nxt = ST_SEARCH;
            endcase
        end
    end

    assign lock_nxt = (state_nxt == ST_LOCKED);

    // Stored comparison set and published timing
    always_ff @(posedge clk) begin
        if (reset) begin
            st_htot  <= '0;
            st_hact  <= '0;
            st_vtot  <= '0;
            st_vact  <= '0;
            st_vld   <= 1'b0;
            h_total  <= '0;
            h_active <= '0;
            v_total  <= '0;
            v_active <= '0;
        end else begin
            if (clr_meas) begin
                st_vld <= 1'b0;
            end else if (store_en) begin
                st_htot <= h_meas;
                st_hact <= h_act_meas;
                st_vtot <= vcnt;
                st_vact <= vact;
                st_vld  <= 1'b1;
            end
            if (publish_en) begin
                h_total  <= h_meas;
                h_active <= h_act_meas;
                v_total  <= vcnt;
                v_active <= vact;
            end
        end
    end

    // Column/row of the pixel currently in the input stage
    assign new_frame = row_pend | vs_rise;
    assign col       = de_q ? x_cnt : '0;
    assign row       = new_frame ? '0 : (y_cnt + V_CNT_W'(1));

    // Pixel tagging; the live vid_de gives eol its one cycle of lookahead
    always_ff @(posedge clk) begin
        if (reset) begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            row_pend  <= 1'b1;
            pix_d     <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_valid <= 1'b0;
            sof       <= 1'b0;
            eol       <= 1'b0;
        end else begin
            pix_d     <= d_r;
            pix_valid <= lock_nxt & de_r;
            sof       <= lock_nxt & de_rise & new_frame;
            eol       <= lock_nxt & de_r & ~vid_de;
            if (de_r) begin
                pix_x <= col;
                x_cnt <= col + H_CNT_W'(1);
            end
            if (de_rise) begin
                y_cnt    <= row;
                pix_y    <= row;
                row_pend <= 1'b0;
            end else begin
                if (de_r)    pix_y    <= y_cnt;
                if (vs_rise) row_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_rx_timing_detect.sv
// Bench for hdmi_rx_timing_detect using two small video formats so several
// frames fit in a short run; expected pixel tags go through a scoreboard queue.
module tb_hdmi_rx_timing_detect;

    localparam int unsigned H_W  = 12;
    localparam int unsigned V_W  = 11;
    localparam int          HS_W = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           vid_hs, vid_vs, vid_de;
    logic [23:0]    vid_d;
    logic [23:0]    pix_d;
    logic [H_W-1:0] pix_x;
    logic [V_W-1:0] pix_y;
    logic           pix_valid, sof, eol;
    logic [H_W-1:0] h_total, h_active;
    logic [V_W-1:0] v_total, v_active;
    logic           locked, fmt_change;

    always #5 clk = ~clk;

    hdmi_rx_timing_detect dut (
        .clk        (clk),
        .reset      (reset),
        .vid_hs     (vid_hs),
        .vid_vs     (vid_vs),
        .vid_de     (vid_de),
        .vid_d      (vid_d),
        .pix_d      (pix_d),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_valid  (pix_valid),
        .sof        (sof),
        .eol        (eol),
        .h_total    (h_total),
        .h_active   (h_active),
        .v_total    (v_total),
        .v_active   (v_active),
        .locked     (locked),
        .fmt_change (fmt_change)
    );

    typedef struct {
        bit          chk;
        bit          rstchk;
        bit          valid;
        int          x;
        int          y;
        logic [23:0] d;
        bit          sof;
        bit          eol;
    } exp_t;

    exp_t sb[$];
    exp_t pend;
    exp_t ce;
    bit   pend_vld = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   fmt_cnt = 0;

    // Current source format
    int h_tot, h_act, hde0, v_tot, v_act, vde0, vs_off;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // One input cycle; the expectation for the previous cycle is queued now so a
    // reset driven this cycle can mark it as "outputs already cleared".
    task automatic drive(input logic hs, input logic vs, input logic de, input bit rst,
                         input bit chk_en, input bit vld, input int x, input int y);
        exp_t       e;
        logic [7:0] xb;
        logic [7:0] yb;
        xb     = 8'(x);
        yb     = 8'(y);
        vid_hs = hs;
        vid_vs = vs;
        vid_de = de;
        reset  = rst;
        vid_d  = de ? {xb, yb, 8'hA5} : 24'($urandom);
        if (pend_vld) begin
            if (rst) pend.rstchk = 1'b1;
            sb.push_back(pend);
        end
        e.chk    = chk_en;
        e.rstchk = 1'b0;
        e.valid  = vld;
        e.x      = x;
        e.y      = y;
        e.d      = vid_d;
        e.sof    = vld && (x == 0) && (y == 0);
        e.eol    = vld && (x == h_act - 1);
        pend     = e;
        pend_vld = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    endtask

    // One frame; vld says whether the DUT is expected to be locked for it.
    // A reset at linear cycle rst_at kills the remainder of the frame.
    task automatic run_frame(input bit vld, input int rst_at);
        bit live;
        live = vld;
        for (int ln = 0; ln < v_tot; ln++) begin
            for (int c = 0; c < h_tot; c++) begin
                int lin;
                bit hs, vs, de, r;
                lin = ln * h_tot + c;
                hs  = (c < HS_W);
                vs  = (lin >= vs_off) && (lin < vs_off + 2 * h_tot);
                de  = (ln >= vde0) && (ln < vde0 + v_act) && (c >= hde0) && (c < hde0 + h_act);
                r   = (lin == rst_at);
                if (r) live = 1'b0;
                drive(hs, vs, de, r, 1'b1, live && de, c - hde0, ln - vde0);
            end
        end
    endtask

    // Scoreboard: entries arrive one per cycle, output lags input by 2 clocks
    always @(negedge clk) begin
        if (sb.size() >= 2) begin
            ce = sb.pop_front();
            if (ce.rstchk) begin
                check("rst_pix", {29'd0, pix_valid, sof, eol}, 32'd0);
                check("rst_lock", {31'd0, locked}, 32'd0);
                check("rst_any", {31'd0, |{pix_d, pix_x, pix_y, h_total, h_active,
                                          v_total, v_active, fmt_change}}, 32'd0);
            end else if (ce.chk) begin
                check("pix_valid", {31'd0, pix_valid}, {31'd0, ce.valid});
                if (ce.valid) begin
                    check("pix_x", 32'(pix_x), 32'(ce.x));
                    check("pix_y", 32'(pix_y), 32'(ce.y));
                    check("pix_d", 32'(pix_d), 32'(ce.d));
                    check("sof", {31'd0, sof}, {31'd0, ce.sof});
                    check("eol", {31'd0, eol}, {31'd0, ce.eol});
                end else begin
                    check("idle_strobe", {30'd0, sof, eol}, 32'd0);
                end
            end
        end
        if (fmt_change === 1'b1) fmt_cnt++;
    end

    task automatic check_fmt(input string tag, input int ht, input int ha, input int vt, input int va);
        check({tag, "_h_total"},  32'(h_total),  32'(ht));
        check({tag, "_h_active"}, 32'(h_active), 32'(ha));
        check({tag, "_v_total"},  32'(v_total),  32'(vt));
        check({tag, "_v_active"}, 32'(v_active), 32'(va));
    endtask

    initial begin
        reset  = 1'b1;
        vid_hs = 1'b0;
        vid_vs = 1'b0;
        vid_de = 1'b0;
        vid_d  = '0;
        // Format A: 40x12 total, 24x8 active, HS and VS leading edges coincide
        h_tot = 40; h_act = 24; hde0 = 10; v_tot = 12; v_act = 8; vde0 = 3; vs_off = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
        idle(5);
        check("reset_locked", {31'd0, locked}, 32'd0);
        check("reset_fmt_change", {31'd0, fmt_change}, 32'd0);
        check_fmt("reset", 0, 0, 0, 0);

        // Lock follows the 5th VS edge, i.e. the start of frame 4
        for (int f = 0; f < 7; f++) begin
            run_frame(f >= 4, -1);
            if (f == 3) begin
                check("a_f3_unlocked", {31'd0, locked}, 32'd0);
                check("a_f3_h_total_unpublished", 32'(h_total), 32'd0);
            end
            if (f == 4) begin
                check("a_locked", {31'd0, locked}, 32'd1);
                check_fmt("a", 40, 24, 12, 8);
            end
        end
        check("a_no_fmt_change", 32'(fmt_cnt), 32'd0);
        check("a_still_locked", {31'd0, locked}, 32'd1);

        // Format B: 30x10 total, 16x6 active, VS 3 clocks after HS
        h_tot = 30; h_act = 16; hde0 = 8; v_tot = 10; v_act = 6; vde0 = 3; vs_off = 3;
        for (int f = 0; f < 7; f++) begin
            run_frame(f >= 4, -1);
            if (f == 0) begin
                check("b_fmt_change_once", 32'(fmt_cnt), 32'd1);
                check("b_unlocked", {31'd0, locked}, 32'd0);
            end
            if (f == 3) check("b_f3_unlocked", {31'd0, locked}, 32'd0);
            if (f == 4) begin
                check("b_relocked", {31'd0, locked}, 32'd1);
                check_fmt("b", 30, 16, 10, 6);
            end
        end
        check("b_fmt_change_total", 32'(fmt_cnt), 32'd1);

        // Single-cycle reset in the middle of an active line while locked
        run_frame(1'b1, 4 * h_tot + 12);
        for (int f = 0; f < 6; f++) begin
            run_frame(f >= 4, -1);
            if (f == 0) check("rst_f0_h_total", 32'(h_total), 32'd0);
            if (f == 3) check("rst_f3_unlocked", {31'd0, locked}, 32'd0);
            if (f == 4) begin
                check("rst_relocked", {31'd0, locked}, 32'd1);
                check_fmt("rst", 30, 16, 10, 6);
            end
        end

        // HS/VS held low: hcnt saturates at 4095 clocks after the last HS edge
        idle(4000);
        check("hold_before_sat_locked", {31'd0, locked}, 32'd1);
        idle(200);
        check("hold_lost_lock", {31'd0, locked}, 32'd0);
        check("hold_no_fmt_change", 32'(fmt_cnt), 32'd1);
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
